// File: rtl/trace_history_if.sv
// Tracker-side capture inputs and renderer-side trail outputs of trace_history.
// master = tracker/renderer side, slave = trace_history.
interface trace_history_if #(
  parameter int DEPTH = 5
);
  logic                   nf_in;
  logic                   valid_in;
  logic [11:0]            x_in;
  logic [10:0]            y_in;
  logic [DEPTH*11-1:0]    trail_x_out;
  logic [DEPTH*10-1:0]    trail_y_out;
  logic [DEPTH-1:0]       trail_vld_out;
  logic                   update_out;

  modport master (
    output nf_in, valid_in, x_in, y_in,
    input  trail_x_out, trail_y_out, trail_vld_out, update_out
  );

  modport slave (
    input  nf_in, valid_in, x_in, y_in,
    output trail_x_out, trail_y_out, trail_vld_out, update_out
  );
endinterface

// File: rtl/trace_history.sv
// Per-frame saber tip history with dropout gap-fill and decaying trail.
// Optional frame decimation is enabled by defining TRACE_DECIMATE_EN.
module trace_history #(
  parameter int DEPTH       = 5,
  parameter int HOLD_FRAMES = 2,
  parameter int X_MAX       = 1279,
  parameter int Y_MAX       = 719,
  parameter int DECIM       = 2
) (
  input logic            clk_in,
  input logic            rst_in,
  trace_history_if.slave th
);
  localparam logic [11:0] X_MAX_C    = 12'(X_MAX);
  localparam logic [10:0] Y_MAX_C    = 11'(Y_MAX);
  localparam logic [3:0]  HOLD_C     = 4'(HOLD_FRAMES);
  localparam logic [3:0]  DECIM_LAST = 4'(DECIM - 1);
`ifdef TRACE_DECIMATE_EN
  localparam bit DECIM_ON = 1'b1;
`else
  localparam bit DECIM_ON = 1'b0;
`endif

  // Compare at full input width so out-of-range values clip instead of wrapping.
  function automatic logic [10:0] clip_x(input logic [11:0] x);
    return (x > X_MAX_C) ? X_MAX_C[10:0] : x[10:0];
  endfunction

  function automatic logic [9:0] clip_y(input logic [10:0] y);
    return (y > Y_MAX_C) ? Y_MAX_C[9:0] : y[9:0];
  endfunction

  logic [DEPTH-1:0][10:0] hist_x_p1, x_p0;
  logic [DEPTH-1:0][9:0]  hist_y_p1, y_p0;
  logic [DEPTH-1:0]       vld_p1, vld_p0;
  logic                   upd_p1;
  logic [3:0]             miss_cnt, miss_p0;
  logic [3:0]             dec_cnt;
  logic                   capture_p0;

  // Stage p0: decide capture and build the next history from the current one.
  assign capture_p0 = th.nf_in && (!DECIM_ON || (dec_cnt == 4'd0));

  always_comb begin
    x_p0    = hist_x_p1;
    y_p0    = hist_y_p1;
    vld_p0  = vld_p1;
    miss_p0 = miss_cnt;
    if (capture_p0) begin
      // Shifting with slot0 duplicated leaves the held position in place by default.
      x_p0   = {hist_x_p1[DEPTH-2:0], hist_x_p1[0]};
      y_p0   = {hist_y_p1[DEPTH-2:0], hist_y_p1[0]};
      vld_p0 = {vld_p1[DEPTH-2:0], vld_p1[0]};
      if (th.valid_in) begin
        x_p0[0]   = clip_x(th.x_in);
        y_p0[0]   = clip_y(th.y_in);
        vld_p0[0] = 1'b1;
        miss_p0   = 4'd0;
      end else begin
        if (!(vld_p1[0] && (miss_cnt < HOLD_C))) begin
          x_p0[0]   = 11'd0;
          y_p0[0]   = 10'd0;
          vld_p0[0] = 1'b0;
        end
        if (miss_cnt != HOLD_C) miss_p0 = miss_cnt + 4'd1;
      end
    end
  end

  // Stage p1: registered history, visible one cycle after the capture event.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hist_x_p1 <= '0;
      hist_y_p1 <= '0;
      vld_p1    <= '0;
      upd_p1    <= 1'b0;
      miss_cnt  <= 4'd0;
      dec_cnt   <= 4'd0;
    end else begin
      hist_x_p1 <= x_p0;
      hist_y_p1 <= y_p0;
      vld_p1    <= vld_p0;
      upd_p1    <= capture_p0;
      miss_cnt  <= miss_p0;
      if (th.nf_in) dec_cnt <= (dec_cnt == DECIM_LAST) ? 4'd0 : dec_cnt + 4'd1;
    end
  end

  assign th.trail_x_out   = hist_x_p1;
  assign th.trail_y_out   = hist_y_p1;
  assign th.trail_vld_out = vld_p1;
  assign th.update_out    = upd_p1;
endmodule
